// File: rtl/bsg_tag_boot_sequencer_pkg.sv
// Shared definitions for the bsg_tag boot sequencer: default geometry of the
// tag network, the ROM entry layout, and the sequencer FSM state encoding.
// The DELAY state exists only when BSG_TAG_BOOT_SEQ_DELAY_EN is defined.
package bsg_tag_boot_sequencer_pkg;

  localparam int tag_els_gp               = 32;
  localparam int tag_lg_els_gp            = $clog2(tag_els_gp);
  localparam int tag_lg_width_gp          = 5;
  localparam int tag_max_payload_width_gp = 16;
  localparam int boot_rom_addr_width_gp   = 8;
  localparam int boot_preamble_ones_gp    = 40;
  localparam int boot_preamble_zeros_gp   = 8;
  localparam int boot_gap_zeros_gp        = 4;

  // One ROM word, MSB to LSB.
  typedef struct packed {
    logic                                last;
    logic [tag_lg_els_gp-1:0]            node_id;
    logic                                data_not_reset;
    logic [tag_lg_width_gp-1:0]          len;
    logic [tag_max_payload_width_gp-1:0] payload;
  } bsg_tag_boot_entry_s;

  typedef enum logic [2:0] {
    BOOT_IDLE,
    BOOT_PRE1,
    BOOT_PRE0,
    BOOT_FETCH,
    BOOT_SEND,
    BOOT_GAP,
    BOOT_DONE
`ifdef BSG_TAG_BOOT_SEQ_DELAY_EN
    , BOOT_DELAY
`endif
  } boot_state_e;

  function automatic int boot_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bsg_tag_boot_serializer.sv
// Parallel-load shift register plus down-counter for one tag packet body.
// The start bit is produced by the sequencer; this block holds everything
// after it (node_id, data_not_reset, len, payload), each field LSB first.
// Ports:
//   clk_i, reset_n_i  clock, async active-low reset
//   load_v_i          capture entry_i and load the remaining-bit count
//   shift_v_i         advance one bit
//   entry_i           ROM entry without its 'last' bit
//   bit_o             next bit to be sent
//   last_bit_o        counter at zero: the bit currently on the line is final
module bsg_tag_boot_serializer
  import bsg_tag_boot_sequencer_pkg::*;
#(
  parameter int lg_els_p            = tag_lg_els_gp,
  parameter int lg_width_p          = tag_lg_width_gp,
  parameter int max_payload_width_p = tag_max_payload_width_gp,
  localparam int body_width_lp      = lg_els_p + 1 + lg_width_p + max_payload_width_p,
  localparam int cnt_width_lp       = $clog2(body_width_lp + 1)
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     load_v_i,
  input  logic                     shift_v_i,
  input  logic [body_width_lp-1:0] entry_i,
  output logic                     bit_o,
  output logic                     last_bit_o
);

  logic [max_payload_width_p-1:0] payload;
  logic [lg_width_p-1:0]          len;
  logic                           dnr;
  logic [lg_els_p-1:0]            node;
  logic [body_width_lp-1:0]       shift_q;
  logic [cnt_width_lp-1:0]        cnt_q;

  assign payload = entry_i[max_payload_width_p-1:0];
  assign len     = entry_i[max_payload_width_p +: lg_width_p];
  assign dnr     = entry_i[max_payload_width_p + lg_width_p];
  assign node    = entry_i[max_payload_width_p + lg_width_p + 1 +: lg_els_p];

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (load_v_i) begin
      // Reordered so the first header field sits at bit 0.
      shift_q <= {payload, len, dnr, node};
      // Bits remaining after the start bit.
      cnt_q   <= cnt_width_lp'(lg_els_p + 1 + lg_width_p) + cnt_width_lp'(len);
    end else if (shift_v_i) begin
      shift_q <= shift_q >> 1;
      cnt_q   <= (cnt_q == '0) ? '0 : cnt_q - cnt_width_lp'(1);
    end
  end

  assign bit_o      = shift_q[0];
  assign last_bit_o = (cnt_q == '0);

endmodule

// File: rtl/bsg_tag_boot_sequencer.sv
// On-chip bring-up controller: replays a ROM-resident list of bsg_tag packets
// into the tag master serial input (preamble, then one packet per entry).
// Optional feature macro: BSG_TAG_BOOT_SEQ_DELAY_EN (node_id all-ones entries
// become wait commands of payload+1 idle cycles instead of packets).
// Ports:
//   clk_i, reset_n_i  clock, async active-low reset
//   start_i           pulse; starts a sequence when idle
//   rom_addr_o        ROM read address
//   rom_data_i        ROM word, valid one cycle after rom_addr_o changes
//   tag_data_o        registered serial tag bit
//   busy_o            sequence in progress
//   done_o / err_o    sticky completion / malformed-entry abort
//
// state | meaning
// IDLE  | waiting for start_i, address held at 0
// PRE1  | preamble ones resetting the tag master
// PRE0  | preamble zeros
// FETCH | ROM read cycle, entry latched at its end
// SEND  | packet bits on the line
// GAP   | idle zeros between packets
// DELAY | idle zeros for payload+1 cycles (feature build only)
// DONE  | one cycle before returning to IDLE
module bsg_tag_boot_sequencer
  import bsg_tag_boot_sequencer_pkg::*;
#(
  parameter int els_p               = tag_els_gp,
  parameter int lg_width_p          = tag_lg_width_gp,
  parameter int max_payload_width_p = tag_max_payload_width_gp,
  parameter int rom_addr_width_p    = boot_rom_addr_width_gp,
  parameter int preamble_ones_p     = boot_preamble_ones_gp,
  parameter int preamble_zeros_p    = boot_preamble_zeros_gp,
  parameter int gap_zeros_p         = boot_gap_zeros_gp,
  localparam int lg_els_lp          = $clog2(els_p),
  localparam int entry_width_lp     = 2 + lg_els_lp + lg_width_p + max_payload_width_p
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic                        start_i,
  output logic [rom_addr_width_p-1:0] rom_addr_o,
  input  logic [entry_width_lp-1:0]   rom_data_i,
  output logic                        tag_data_o,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        err_o
);

  // Longest packet is exactly entry_width_lp bits (start + header + payload).
  localparam int cnt_base_lp = boot_max(boot_max(preamble_ones_p, preamble_zeros_p),
                                        boot_max(gap_zeros_p, entry_width_lp));
`ifdef BSG_TAG_BOOT_SEQ_DELAY_EN
  localparam int cnt_max_lp  = boot_max(cnt_base_lp, (1 << max_payload_width_p) - 1);
`else
  localparam int cnt_max_lp  = cnt_base_lp;
`endif
  localparam int cnt_width_lp = $clog2(cnt_max_lp + 1);

  boot_state_e                 state_q;
  logic [cnt_width_lp-1:0]     cnt_q, cnt_dec;
  logic                        cnt_zero;
  logic [rom_addr_width_p-1:0] addr_q;
  logic                        tag_q, busy_q, done_q, err_q, last_q;
  logic                        entry_last;
  logic [lg_width_p-1:0]       entry_len;
  logic                        ser_bit, ser_last;

  assign entry_last = rom_data_i[entry_width_lp-1];
  assign entry_len  = rom_data_i[max_payload_width_p +: lg_width_p];
  assign cnt_zero   = (cnt_q == '0);
  assign cnt_dec    = cnt_zero ? '0 : cnt_q - cnt_width_lp'(1);

`ifdef BSG_TAG_BOOT_SEQ_DELAY_EN
  logic [lg_els_lp-1:0]           entry_node;
  logic [max_payload_width_p-1:0] entry_payload;
  assign entry_node    = rom_data_i[max_payload_width_p + lg_width_p + 1 +: lg_els_lp];
  assign entry_payload = rom_data_i[max_payload_width_p-1:0];
`endif

  bsg_tag_boot_serializer #(
    .lg_els_p           (lg_els_lp),
    .lg_width_p         (lg_width_p),
    .max_payload_width_p(max_payload_width_p)
  ) serializer (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .load_v_i  (state_q == BOOT_FETCH),
    .shift_v_i ((state_q == BOOT_SEND) && !ser_last),
    .entry_i   (rom_data_i[entry_width_lp-2:0]),
    .bit_o     (ser_bit),
    .last_bit_o(ser_last)
  );

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= BOOT_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      tag_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      case (state_q)
        BOOT_IDLE: begin
          addr_q <= '0;
          tag_q  <= 1'b0;
          if (start_i) begin
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b1;
            tag_q   <= 1'b1;
            cnt_q   <= cnt_width_lp'(preamble_ones_p - 1);
            state_q <= BOOT_PRE1;
          end
        end
        BOOT_PRE1: begin
          if (cnt_zero) begin
            tag_q   <= 1'b0;
            cnt_q   <= cnt_width_lp'(preamble_zeros_p - 1);
            state_q <= BOOT_PRE0;
          end else begin
            cnt_q <= cnt_dec;
          end
        end
        BOOT_PRE0: begin
          if (cnt_zero) state_q <= BOOT_FETCH;
          else          cnt_q   <= cnt_dec;
        end
        BOOT_FETCH: begin
          last_q <= entry_last;
`ifdef BSG_TAG_BOOT_SEQ_DELAY_EN
          if (entry_node == '1) begin
            cnt_q   <= cnt_width_lp'(entry_payload);
            state_q <= BOOT_DELAY;
          end else
`endif
          if (int'(entry_len) > max_payload_width_p) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= BOOT_DONE;
          end else begin
            tag_q   <= 1'b1;  // start bit
            state_q <= BOOT_SEND;
          end
        end
        BOOT_SEND: begin
          if (ser_last) begin
            tag_q   <= 1'b0;
            cnt_q   <= cnt_width_lp'(gap_zeros_p - 1);
            state_q <= BOOT_GAP;
          end else begin
            tag_q <= ser_bit;
          end
        end
`ifdef BSG_TAG_BOOT_SEQ_DELAY_EN
        BOOT_GAP, BOOT_DELAY: begin
`else
        BOOT_GAP: begin
`endif
          if (!cnt_zero) begin
            cnt_q <= cnt_dec;
          end else if (last_q) begin
            busy_q  <= 1'b0;
            done_q  <= ~err_q;
            state_q <= BOOT_DONE;
          end else begin
            addr_q  <= addr_q + 1'b1;  // wraps with no error
            state_q <= BOOT_FETCH;
          end
        end
        BOOT_DONE: state_q <= BOOT_IDLE;
        default:   state_q <= BOOT_IDLE;
      endcase
    end
  end

  assign rom_addr_o = addr_q;
  assign tag_data_o = tag_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign err_o      = err_q;

endmodule
